// File: rtl/sort_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : sort_frame_packer
// Purpose  : Packs a stream of narrow elements into one frame (element count
//            plus packed data word) for the sort stage. The frame is held on
//            the output until the sort stage accepts it.
// Ports    : clk, rst        - clock and synchronous active-high reset
//            in_valid/in_ready/in_data/in_last - element input handshake
//            out_valid/out_ready/out_int/out_data - frame output handshake
//            frame_cnt       - frames delivered since reset (wraps)
// Options  : SORT_PACK_TIMEOUT_EN - when defined, a partial frame is closed
//            after TIMEOUT consecutive cycles without an accepted element.
// Revision : 1.0 - initial release
// ============================================================================
module sort_frame_packer #(
   parameter int ELEM_W   = 2,
   parameter int NUM_ELEM = 5,
   parameter int CNT_W    = 5,
   parameter int TIMEOUT  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ELEM_W-1:0]          in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           out_int,
   output logic [NUM_ELEM*ELEM_W-1:0] out_data,
   output logic [7:0]                 frame_cnt
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_FILL = 2'd1;
   localparam logic [1:0] c_HOLD = 2'd2;

   localparam logic [CNT_W-1:0] c_LAST_SLOT = CNT_W'(NUM_ELEM - 1);

   logic [1:0]                 r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic [NUM_ELEM*ELEM_W-1:0] r_buf;
   logic [7:0]                 r_frames;

   logic w_accept;
   logic w_timeout;

   assign in_ready  = !rst && (r_state != c_HOLD);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == c_HOLD);
   assign out_int   = r_cnt;
   assign out_data  = r_buf;
   assign frame_cnt = r_frames;

`ifdef SORT_PACK_TIMEOUT_EN
   localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

   logic [c_IDLE_W-1:0] r_idle;

   // Counts consecutive FILL cycles without an accepted element; any other
   // state (including entry to IDLE) keeps it at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idle <= '0;
      end else if ((r_state != c_FILL) || w_accept) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + c_IDLE_W'(1);
      end
   end

   // Fires on the idle cycle that brings the count to TIMEOUT.
   assign w_timeout = (r_state == c_FILL) && !w_accept &&
                      (r_idle == c_IDLE_W'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= c_IDLE;
         r_cnt    <= '0;
         r_buf    <= '0;
         r_frames <= '0;
      end else begin
         case (r_state)
            // IDLE and FILL share the store path: in IDLE r_cnt is zero, so
            // the first element lands in slot 0. The slot-(NUM_ELEM-1) check
            // also covers NUM_ELEM==1 straight from IDLE.
            c_IDLE, c_FILL: begin
               if (w_accept) begin
                  for (int k = 0; k < NUM_ELEM; k++) begin
                     if (r_cnt == CNT_W'(k)) begin
                        r_buf[k*ELEM_W +: ELEM_W] <= in_data;
                     end
                  end
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= (in_last || (r_cnt == c_LAST_SLOT)) ? c_HOLD : c_FILL;
               end else if (w_timeout) begin
                  r_state <= c_HOLD;
               end
            end
            c_HOLD: begin
               if (out_ready) begin
                  r_state  <= c_IDLE;
                  r_cnt    <= '0;
                  r_buf    <= '0;
                  r_frames <= r_frames + 8'd1;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_frame_packer
// Purpose  : Self-checking bench for sort_frame_packer. Directed steps from
//            the test plan followed by random traffic, all compared against a
//            queue-based frame model.
// Options  : SORT_PACK_TIMEOUT_EN - selects the expected timeout behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_frame_packer;

   localparam int ELEM_W   = 2;
   localparam int NUM_ELEM = 5;
   localparam int CNT_W    = 5;
   localparam int TIMEOUT  = 8;
`ifdef SORT_PACK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       in_valid = 1'b0;
   logic                       in_ready;
   logic [ELEM_W-1:0]          in_data = '0;
   logic                       in_last = 1'b0;
   logic                       out_valid;
   logic                       out_ready = 1'b0;
   logic [CNT_W-1:0]           out_int;
   logic [NUM_ELEM*ELEM_W-1:0] out_data;
   logic [7:0]                 frame_cnt;

   sort_frame_packer #(
      .ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
      .out_data(out_data), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: elements of the open frame, whether a frame is waiting
   // at the output, frames delivered, and idle cycles of an open frame.
   int m_q[$];
   bit m_hold   = 1'b0;
   int m_frames = 0;
   int m_idle   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_q();
      logic [31:0] r;
      r = '0;
      foreach (m_q[i]) r = r | (32'(m_q[i]) << (i * ELEM_W));
      return r;
   endfunction

   // One clock: drive inputs, compare outputs with the model, clock, update model.
   task automatic step(input bit v, input int d, input bit last, input bit ordy);
      bit acc_in, acc_out;
      in_valid  = v;
      in_data   = ELEM_W'(d);
      in_last   = last;
      out_ready = ordy;
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      if (m_hold) begin
         chk("out_int", 32'(out_int), 32'(m_q.size()));
         chk("out_data", 32'(out_data), pack_q());
      end
      acc_out = m_hold && ordy;
      acc_in  = v && !m_hold;
      @(posedge clk);
      #1;
      if (acc_out) begin
         m_hold = 1'b0;
         m_q.delete();
         m_frames = (m_frames + 1) % 256;
      end else if (acc_in) begin
         m_q.push_back(d);
         m_idle = 0;
         if (last || m_q.size() == NUM_ELEM) m_hold = 1'b1;
      end else if (!m_hold && m_q.size() > 0) begin
         m_idle++;
         if (TO_EN && m_idle == TIMEOUT) m_hold = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_int", 32'(out_int), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      m_q.delete(); m_hold = 1'b0; m_frames = 0; m_idle = 0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic chk_frame(input string tag, input int cnt, input int data);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_int"}, 32'(out_int), 32'(cnt));
      chk({tag, "_data"}, 32'(out_data), 32'(data));
   endtask

   initial begin
      // Reset and a 3-element frame, sink always ready.
      do_reset();
      step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 1, 1);
      chk_frame("f3", 3, 10'b00000_11_10_01);
      step(0, 0, 0, 1);
      chk("f3_frame_cnt", 32'(frame_cnt), 32'd1);

      // Overflow: sixth element starts a new frame.
      step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 1, 0, 0);
      chk_frame("ovf1", 5, 10'b01_11_10_01_00);
      step(1, 2, 0, 0);                       // refused: frame still held
      chk_frame("ovf1_hold", 5, 10'b01_11_10_01_00);
      step(0, 0, 0, 1);
      step(1, 2, 0, 0); step(1, 3, 1, 0);
      chk_frame("ovf2", 2, 10'b00000_11_10);
      step(0, 0, 0, 1);

      // Single-element frame held for 10 cycles.
      step(1, 3, 1, 0);
      for (int i = 0; i < 10; i++) begin
         chk_frame("hold1", 1, 10'b0000000011);
         chk("hold1_in_ready", 32'(in_ready), 32'd0);
         step(0, 0, 0, 0);
      end
      step(0, 0, 0, 1);
      chk("turnaround_in_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of a frame discards it.
      step(1, 1, 0, 0); step(1, 2, 0, 0);
      do_reset();
      step(1, 2, 1, 0);
      chk_frame("after_rst", 1, 10'b0000000010);
      step(0, 0, 0, 1);

      // frame_cnt wraps after 256 deliveries.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         step(1, i % 4, 1, 0);
         step(0, 0, 0, 1);
         if (i == 254) chk("frame_cnt_255", 32'(frame_cnt), 32'd255);
      end
      chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

      // Partial frame left idle.
      step(1, 1, 0, 0); step(1, 2, 0, 0);
      if (TO_EN) begin
         for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
         chk("to_before", 32'(out_valid), 32'd0);
         step(0, 0, 0, 0);
         chk_frame("to_frame", 2, 10'b00000_00_10_01);
         step(0, 0, 0, 1);
      end else begin
         for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
         chk("no_to_valid", 32'(out_valid), 32'd0);
         step(1, 3, 1, 0);
         chk_frame("no_to_close", 3, 10'b00000_11_10_01);
         step(0, 0, 0, 1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sort_frame_packer.md
Name: sort_frame_packer

Overview:
- Upstream feeder for the sort stage: collects a stream of narrow elements and packs them into one frame.
- Each frame carries an element count (int) and a packed data word (data), in the form the sort stage consumes.
- Handles frame closing, zero-fill of unused slots and output hold until the sort stage accepts the frame.
- Sits between the element source and the sort input.

Parameters:
ELEM_W, 2, width of one element in bits
NUM_ELEM, 5, maximum elements per frame
CNT_W, 5, width of the count output (must hold NUM_ELEM)
TIMEOUT, 8, idle cycles before a partial frame is force-closed (only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  element valid
in_ready  output  1  packer can accept an element
in_data  input  ELEM_W  element value
in_last  input  1  element closes the current frame
out_valid  output  1  frame valid toward sort stage
out_ready  input  1  sort stage accepts frame
out_int  output  CNT_W  number of valid elements in frame, 1..NUM_ELEM
out_data  output  NUM_ELEM*ELEM_W  packed elements
frame_cnt  output  8  frames delivered since reset, wraps 255->0

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, in_ready=0 during reset then 1, out_valid=0, out_int=0, out_data=0, frame_cnt=0, internal count=0. Reset mid-frame or mid-HOLD discards the frame silently.
- Transfer rules: input element accepted when in_valid & in_ready at a clk edge. Output frame accepted when out_valid & out_ready.
- in_ready = 1 in IDLE and FILL, 0 in HOLD and during reset.
- Packing: element k of a frame (k=0 first accepted) is written to out_data[k*ELEM_W +: ELEM_W]. Element 0 occupies the LSBs. Slots >= count are 0.
- States:
  - IDLE: accept -> store element 0, count=1. If in_last, or NUM_ELEM==1 -> HOLD, else -> FILL.
  - FILL: accept -> store at slot count, count+1. Closes when in_last=1 or count reaches NUM_ELEM -> HOLD.
  - HOLD: out_valid=1. out_int and out_data held stable until accepted. On acceptance -> IDLE, buffer cleared to 0, frame_cnt+1.
- Latency: out_valid rises the cycle after the closing element is accepted. After the output handshake, in_ready is 1 in the next cycle (one-bubble turnaround; no overlap).
- Overflow: the element that fills slot NUM_ELEM-1 closes the frame regardless of in_last. The next element starts a new frame.
- in_last on the first element gives out_int=1.
- out_int is never 0 while out_valid=1. No empty frames are produced.
- in_data and in_last are ignored when in_valid=0.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro SORT_PACK_TIMEOUT_EN.
- When defined: in FILL, an idle counter increments each cycle with no accepted element and clears on accept. When it reaches TIMEOUT, the partial frame closes -> HOLD, with out_int = current count. The counter is cleared on reset and on entry to IDLE.
- When not defined: no counter exists and FILL waits indefinitely for in_last or a full frame.

Test Plan:
- Reset, then send 3 elements 01,10,11 (last on 3rd) with out_ready=1 -> out_int=3, out_data=10'b00000_11_10_01 one cycle after 3rd accept; frame_cnt=1.
- Send 6 elements 00,01,10,11,01,10 with no in_last, then 7th 11 with last -> frame1 out_int=5, out_data=10'b01_11_10_01_00; frame2 out_int=2, out_data=10'b00000_00_11_10.
- Single element 11 with in_last, hold out_ready=0 for 10 cycles -> out_valid=1, out_int=1, out_data=10'b0000000011 stable all 10 cycles; in_ready=0. Then out_ready=1 -> in_ready=1 next cycle.
- Assert rst for 1 cycle after 2 elements accepted in FILL -> all outputs 0. Next frame of 1 element (10, last) gives out_int=1, out_data=10'b10.
- Deliver 256 single-element frames -> frame_cnt wraps to 0.
- With SORT_PACK_TIMEOUT_EN, TIMEOUT=8: send 2 elements, then in_valid=0 -> out_valid rises 8 idle cycles later with out_int=2. Without the macro, out_valid stays 0 for 100 cycles.
